// File: rtl/saci_slave.sv
// rtl/saci_slave.sv - SACI serial slave: frame receive, register request/ack handshake, serial response
//
// Receives a command frame on cmd_i while sel_n_i is low, presents the decoded
// access on req_o/wr_o/cmd_o/addr_o/wdata_o, waits for ack_i, then shifts the
// response frame out on rsp_o. Frame layout, MSB first:
//     start(1) | R/W(1, 1 = write) | cmd | addr | [data]
// Data follows a write request and a read response only.
//
// Ports:
//     clk_i     - SACI clock, rising edge
//     reset_i   - asynchronous active-high reset
//     sel_n_i   - active-low chip select; high mid-transfer aborts
//     cmd_i     - serial command in
//     rsp_o     - serial response out (registered, 0 outside ST_TX)
//     req_o     - register access request, high for all ST_EXEC cycles
//     wr_o      - 1 = write access, 0 = read access
//     cmd_o     - decoded command
//     addr_o    - decoded address
//     wdata_o   - decoded write data (held on reads)
//     ack_i     - register access acknowledge, sampled only in ST_EXEC
//     rdata_i   - read data, valid while ack_i = 1
//     busy_o    - high whenever the block is not in ST_IDLE

module saci_slave #(
    parameter int g_cmd_width  = 7,
    parameter int g_addr_width = 12,
    parameter int g_data_width = 32
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    sel_n_i,
    input  logic                    cmd_i,
    output logic                    rsp_o,
    output logic                    req_o,
    output logic                    wr_o,
    output logic [g_cmd_width-1:0]  cmd_o,
    output logic [g_addr_width-1:0] addr_o,
    output logic [g_data_width-1:0] wdata_o,
    input  logic                    ack_i,
    input  logic [g_data_width-1:0] rdata_i,
    output logic                    busy_o
);

    localparam int L_SHORT = 2 + g_cmd_width + g_addr_width;
    localparam int L_LONG  = L_SHORT + g_data_width;
    // The start bit is never stored, so one bit less than the long frame.
    localparam int SR_W    = L_LONG - 1;
    // Counts 1..L_LONG inclusive without wrapping.
    localparam int CNT_W   = $clog2(L_LONG + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RX,
        ST_EXEC,
        ST_TX
    } state_t;

    state_t                    state;
    logic [CNT_W-1:0]          bit_cnt;
    // Shared shift register: receive frame body in ST_RX, response body in ST_TX.
    logic [SR_W-1:0]           sr;
    logic [SR_W-1:0]           sr_in;
    logic [CNT_W-1:0]          rx_len;
    logic [CNT_W-1:0]          tx_len;
    logic [g_data_width-1:0]   rsp_data;

    assign sr_in    = {sr[SR_W-2:0], cmd_i};
    // wr_o is latched on the bit after the start bit, long before either
    // length can be reached, so it is safe to use here.
    assign rx_len   = wr_o ? CNT_W'(L_LONG)  : CNT_W'(L_SHORT);
    assign tx_len   = wr_o ? CNT_W'(L_SHORT) : CNT_W'(L_LONG);
    assign rsp_data = wr_o ? '0 : rdata_i;
    assign busy_o   = (state != ST_IDLE);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            sr      <= '0;
            rsp_o   <= 1'b0;
            req_o   <= 1'b0;
            wr_o    <= 1'b0;
            cmd_o   <= '0;
            addr_o  <= '0;
            wdata_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // This edge samples the start bit, so it already counts as bit 1.
                    if (!sel_n_i && cmd_i) begin
                        state   <= ST_RX;
                        bit_cnt <= CNT_W'(1);
                    end
                end

                ST_RX: begin
                    if (sel_n_i) begin
                        state <= ST_IDLE;
                    end else begin
                        sr      <= sr_in;
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == CNT_W'(1)) begin
                            wr_o <= cmd_i;
                        end
                        if (bit_cnt + CNT_W'(1) == rx_len) begin
                            state <= ST_EXEC;
                            req_o <= 1'b1;
                            if (wr_o) begin
                                cmd_o   <= sr_in[g_data_width+g_addr_width +: g_cmd_width];
                                addr_o  <= sr_in[g_data_width +: g_addr_width];
                                wdata_o <= sr_in[g_data_width-1:0];
                            end else begin
                                cmd_o   <= sr_in[g_addr_width +: g_cmd_width];
                                addr_o  <= sr_in[g_addr_width-1:0];
                            end
                        end
                    end
                end

                ST_EXEC: begin
                    if (sel_n_i) begin
                        state <= ST_IDLE;
                        req_o <= 1'b0;
                    end else if (ack_i) begin
                        // The start bit goes out immediately; the body is queued
                        // MSB-first, with read data captured from rdata_i here.
                        state   <= ST_TX;
                        req_o   <= 1'b0;
                        rsp_o   <= 1'b1;
                        bit_cnt <= CNT_W'(1);
                        sr      <= {wr_o, cmd_o, addr_o, rsp_data};
                    end
                end

                ST_TX: begin
                    if (sel_n_i || bit_cnt == tx_len) begin
                        state <= ST_IDLE;
                        rsp_o <= 1'b0;
                    end else begin
                        rsp_o   <= sr[SR_W-1];
                        sr      <= {sr[SR_W-2:0], 1'b0};
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/saci_slave.md
SACI_SLAVE -- requirements
Module: saci_slave

Interface
REQ-001 Parameters SHALL be:
- g_cmd_width, default 7, command field width.
- g_addr_width, default 12, address field width.
- g_data_width, default 32, data field width.
REQ-002 Ports SHALL be, in this order:
- clk_i, in, 1, SACI clock; all logic on the rising edge.
- reset_i, in, 1, asynchronous active-high reset.
- sel_n_i, in, 1, chip select, active-low.
- cmd_i, in, 1, serial command (MOSI).
- rsp_o, out, 1, serial response (MISO).
- req_o, out, 1, register access request.
- wr_o, out, 1, 1 = write access, 0 = read access.
- cmd_o, out, g_cmd_width, decoded command.
- addr_o, out, g_addr_width, decoded address.
- wdata_o, out, g_data_width, write data.
- ack_i, in, 1, register access acknowledge.
- rdata_i, in, g_data_width, read data, valid while ack_i=1.
- busy_o, out, 1, high whenever the state is not ST_IDLE.
REQ-003 The clock and reset SHALL be the single clock clk_i and the asynchronous active-high reset reset_i.
REQ-004 Frame layout on both cmd_i and rsp_o SHALL be, MSB first: start bit (1), R/W (1 = write), cmd, addr, then data only when present.
- Data is present for a write request and for a read response.
- With default parameters: L_SHORT = 21 bits, L_LONG = 53 bits.

Function
REQ-005 States SHALL be ST_IDLE, ST_RX, ST_EXEC and ST_TX.
REQ-006 ST_IDLE -> ST_RX SHALL occur on the first edge where sel_n_i=0 and cmd_i=1; that edge samples the start bit.
- cmd_i=1 while sel_n_i=1 SHALL be ignored.
REQ-007 ST_RX SHALL shift cmd_i in on each edge.
- The first bit after the start bit latches wr_o.
- The frame is complete after L_SHORT bits (read) or L_LONG bits (write), counting the start bit.
REQ-008 On the edge sampling the last frame bit, the block SHALL enter ST_EXEC.
- cmd_o, addr_o and wdata_o are updated on that same edge.
- wdata_o holds its previous value on a read.
REQ-009 req_o SHALL be registered and high for exactly the ST_EXEC cycles; it first goes high in the cycle following the last frame bit.
REQ-010 In ST_EXEC, an edge with ack_i=1 SHALL:
- capture rdata_i (reads only);
- drop req_o;
- enter ST_TX.
- ack_i outside ST_EXEC SHALL be ignored.
REQ-011 ST_EXEC SHALL wait indefinitely for ack_i; there is no internal timeout.
REQ-012 In ST_TX, rsp_o SHALL be registered and drive one bit per cycle, starting in the cycle after ack.
- Bit order: start bit 1, echoed R/W, cmd, addr, then captured rdata for reads only.
- Length: L_LONG bits for a read, L_SHORT bits for a write.
REQ-013 After the last response bit, the block SHALL return to ST_IDLE, with rsp_o=0 in the following cycle.
REQ-014 rsp_o SHALL be 0 in every state except ST_TX.
REQ-015 sel_n_i=1 sampled in ST_RX, ST_EXEC or ST_TX SHALL abort the transfer.
- Next state ST_IDLE; req_o=0 and rsp_o=0 from the next cycle.
- Decoded outputs hold their values; no response is sent.
REQ-016 A new start bit SHALL NOT be accepted until the cycle after the return to ST_IDLE.
REQ-017 The bit counter SHALL be sized for L_LONG and SHALL NOT wrap within a frame.

Reset
REQ-018 While reset_i=1, asynchronously, the block SHALL force:
- state = ST_IDLE;
- rsp_o = 0, req_o = 0, wr_o = 0, busy_o = 0;
- cmd_o, addr_o and wdata_o to all zeros;
- the bit counter and the captured read data to zeros.
REQ-019 A reset asserted mid-frame SHALL discard the frame.
- After release, the block waits for a fresh start bit with sel_n_i=0.

Verification
REQ-020 Write: sel_n_i=0, frame 1,1,cmd=7'h15,addr=12'hABC,data=32'hDEADBEEF, ack_i one cycle after req_o rises -> req_o=1, wr_o=1, cmd_o=7'h15, addr_o=12'hABC, wdata_o=32'hDEADBEEF; rsp_o returns 21 bits 1,1,7'h15,12'hABC.
REQ-021 Read: frame 1,0,cmd=7'h02,addr=12'h010; ack_i after 5 cycles with rdata_i=32'h12345678 -> req_o high for exactly 5 cycles plus the ack cycle; rsp_o returns 53 bits 1,0,7'h02,12'h010,32'h12345678.
REQ-022 Abort: sel_n_i rises after 10 bits of a write frame -> state ST_IDLE, req_o never asserts, rsp_o stays 0, busy_o=0 the next cycle.
REQ-023 Reset in ST_TX: reset_i pulses during the 8th response bit -> rsp_o=0 immediately; the next valid frame completes normally.
REQ-024 Noise: cmd_i toggling with sel_n_i=1 for 100 cycles, and ack_i pulses in ST_IDLE -> busy_o=0, req_o=0, rsp_o=0 throughout.
REQ-025 Back-to-back: a second read frame starting the cycle after the first response ends is accepted and answered correctly.
